// File: rtl/sp_ram_ctrl.sv
// Single-port synchronous RAM bus master: valid/ready requests in, RAM strobes and tristate bus out.
// Optional macro SP_RAM_CTRL_TURNAROUND_EN inserts one idle bus cycle after every read.
module sp_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

`ifdef SP_RAM_CTRL_TURNAROUND_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ_ADDR, READ_DATA, TURN} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ_ADDR, READ_DATA} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] wdata_q;

  // The bus is owned only while the registered write strobe is up.
  assign mem_data = mem_we ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_address <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mem_address <= req_addr;
            wdata_q     <= req_wdata;
            req_ready   <= 1'b0;
            mem_cs      <= 1'b1;
            if (req_we) begin
              state  <= WRITE;
              mem_we <= 1'b1;
            end else begin
              state  <= READ_ADDR;
              mem_oe <= 1'b1;
            end
          end
        end
        WRITE: begin
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
        READ_ADDR: state <= READ_DATA;
        READ_DATA: begin
          // RAM is driving its registered read word during this cycle.
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_data;
          mem_cs    <= 1'b0;
          mem_oe    <= 1'b0;
`ifdef SP_RAM_CTRL_TURNAROUND_EN
          state     <= TURN;
`else
          state     <= IDLE;
          req_ready <= 1'b1;
`endif
        end
`ifdef SP_RAM_CTRL_TURNAROUND_EN
        TURN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
`endif
        default: begin
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          mem_oe    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Self-checking bench for sp_ram_ctrl: behavioural RAM on the bus plus an array reference model.
module tb_sp_ram_ctrl;
`ifdef SP_RAM_CTRL_TURNAROUND_EN
  localparam int RD_GAP = 4;
  localparam bit TURN_ON = 1'b1;
`else
  localparam int RD_GAP = 3;
  localparam bit TURN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  wire        req_ready, rsp_valid, mem_cs, mem_we, mem_oe;
  wire  [7:0] rsp_rdata, mem_address;
  wire  [7:0] mem_data;

  sp_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_address(mem_address),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered read, drives bus only while enabled for read.
  logic [7:0] ram [256];
  logic [7:0] ram_q;
  logic       ram_drv = 1'b0;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_address] <= mem_data;
    ram_drv <= mem_cs && mem_oe && !mem_we;
    if (mem_cs && mem_oe && !mem_we) ram_q <= ram[mem_address];
  end
  assign mem_data = (ram_drv && mem_oe && !mem_we) ? ram_q : 8'bz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int we_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    if (!rst && (mem_we || mem_oe)) begin
      chk("strobe_needs_cs", mem_cs, 1'b1);
      chk("we_oe_exclusive", mem_we && mem_oe, 1'b0);
    end
  end

  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = '0;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    chk({tag, "_cs_we_oe"}, {mem_cs, mem_we, mem_oe}, 3'b000);
    chk({tag, "_addr"}, mem_address, 8'h00);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int acc;
    issue(1'b1, a, d, acc);
    chk("wr_strobes", {mem_cs, mem_we, mem_oe}, 3'b110);
    chk("wr_addr", mem_address, a);
    chk("wr_bus", mem_data, d);
    chk("wr_ready_low", req_ready, 1'b0);
    ref_mem[a] = d;
    @(negedge clk);
    chk("wr_done_ready", req_ready, 1'b1);
    chk("wr_done_we", mem_we, 1'b0);
    chk("wr_ram", ram[a], d);
  endtask

  task automatic do_read(input logic [7:0] a, input bit tail, output int acc);
    issue(1'b0, a, 8'h00, acc);
    chk("rd_addr_strobes", {mem_cs, mem_we, mem_oe}, 3'b101);
    chk("rd_addr", mem_address, a);
    chk("rd_early_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rd_data_oe", mem_oe, 1'b1);
    chk("rd_bus", mem_data, ref_mem[a]);
    chk("rd_early_rsp2", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_data", rsp_rdata, ref_mem[a]);
    chk("rd_post_cs", mem_cs, 1'b0);
    chk("rd_post_ready", req_ready, !TURN_ON);
    last_rd = ref_mem[a];
    if (tail) begin
      @(negedge clk);
      chk("rd_pulse_one", rsp_valid, 1'b0);
      chk("rd_hold", rsp_rdata, last_rd);
    end
  endtask

  initial begin
    int acc, acc2, accs, prev, w0;
    logic [7:0] a, d;
    bit we;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("por");
    chk("por_bus_undriven", mem_we, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    do_write(8'h10, 8'h5A);
    do_read(8'h10, 1'b1, acc);

    // Full sweep, crossing the 0xFF -> 0x00 wrap.
    for (int i = 0; i < 256; i++) do_write(8'(i), 8'(i) ^ 8'hFF);
    for (int i = 0; i < 256; i++) do_read(8'(i + 128), 1'b1, acc);

    // Read then write: bus handover gap.
    do_write(8'h20, 8'hC3);
    do_read(8'h20, 1'b0, acc);
    issue(1'b1, 8'h21, 8'h3C, acc2);
    ref_mem[8'h21] = 8'h3C;
    chk("rd_wr_gap", acc2 - acc, RD_GAP);
    chk("rd_wr_bus", mem_data, 8'h3C);
    @(negedge clk);
    chk("rd_wr_ram", ram[8'h21], 8'h3C);

    // Reset during READ_ADDR.
    issue(1'b0, 8'h21, 8'h00, acc);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rd");
    rst = 1'b0;
    last_rd = 8'h00;
    @(negedge clk);
    chk("rst_rd_no_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rst_rd_no_rsp2", rsp_valid, 1'b0);
    do_read(8'h21, 1'b1, acc);

    // req_valid held for 10 cycles: one acceptance every other cycle.
    w0 = we_cycles; accs = 0; prev = -1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h77;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) begin
        accs++;
        if (prev >= 0) chk("held_gap", cyc - prev, 2);
        prev = cyc;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    ref_mem[8'h40] = 8'h77;
    @(negedge clk);
    chk("held_accepts", accs, 5);
    chk("held_we_cycles", we_cycles - w0, 5);

    // Random traffic with occasional mid-transaction resets.
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        issue(we, a, d, acc);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check_reset_outputs("rst_rand");
        chk("rst_rand_bus_undriven", mem_we, 1'b0);
        if (we) begin
          ref_mem[a] = d;
          chk("rst_rand_wr_lands", ram[a], d);
        end
        rst = 1'b0;
        last_rd = 8'h00;
        @(negedge clk);
        chk("rst_rand_ready", req_ready, 1'b1);
      end else if (we) begin
        do_write(a, d);
      end else begin
        do_read(a, 1'b1, acc);
      end
    end
    do_read(8'h40, 1'b1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end
endmodule
